// File: rtl/uart_rx_fifo.sv
// Receive byte queue between the UART receiver and the register interface.
// Show-ahead read port, sticky overflow, idle timeout and a single level IRQ.
module uart_rx_fifo #(
  parameter int          DEPTH       = 16,
  parameter int          AW          = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4000
) (
  input  logic          clk,
  input  logic          RSTn,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  input  logic          flush,
  input  logic          ovf_clr,
  input  logic [AW:0]   irq_thresh,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          timeout,
  output logic          irq
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   thresh_q;
  logic [15:0]   idle;
  logic          ovf_q;
  logic          pop, push, drop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign count   = cnt;
  assign ovf     = ovf_q;
  assign rd_data = mem[rd_ptr];

  assign pop  = rd_en && !empty;
  // A full queue still accepts a byte when a pop frees the head slot this cycle.
  assign push = rx_valid && (!full || pop);
  assign drop = rx_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      idle     <= '0;
      ovf_q    <= 1'b0;
      thresh_q <= '0;
    end else begin
      thresh_q <= irq_thresh;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        idle   <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
        if (push || pop || empty)
          idle <= '0;
        else if (idle != TIMEOUT_CYC)
          idle <= idle + 16'd1;
      end
      // A dropped byte outranks a same-cycle clear; a flushed push never overflows.
      if (drop && !flush)
        ovf_q <= 1'b1;
      else if (ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  // The threshold is sampled so irq depends on flops only.
  assign timeout = (idle == TIMEOUT_CYC);
  assign irq     = ((thresh_q != '0) && (cnt >= thresh_q)) || timeout || ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for basic push/pop/threshold
// behaviour plus hand sequences for overflow, wrap, timeout, flush and reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       RSTn;
  logic       rx_valid, rd_en, flush, ovf_clr;
  logic [7:0] rx_data, rd_data;
  logic [4:0] irq_thresh, count;
  logic       empty, full, ovf, timeout, irq;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH(16), .AW(4), .TIMEOUT_CYC(16'd8)) dut (
    .clk(clk), .RSTn(RSTn), .rx_valid(rx_valid), .rx_data(rx_data),
    .rd_en(rd_en), .rd_data(rd_data), .flush(flush), .ovf_clr(ovf_clr),
    .irq_thresh(irq_thresh), .empty(empty), .full(full), .count(count),
    .ovf(ovf), .timeout(timeout), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rv;
    logic [7:0] d;
    logic       re;
    logic [4:0] th;
    logic [4:0] cnt;
    logic       emp;
    logic       irq;
    logic       chk_rd;
    logic [7:0] rd;
  } vec_t;

  vec_t tv[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rv, input logic [7:0] d, input logic re,
                      input logic fl, input logic oc);
    rx_valid = rv; rx_data = d; rd_en = re; flush = fl; ovf_clr = oc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0; rd_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fill16(input logic [7:0] base);
    for (int i = 0; i < 16; i++) step(1'b1, base + 8'(i), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    //        rv    d      re    th     cnt    emp   irq   chk   rd
    tv[0]  = '{1'b1, 8'h41, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h41};
    tv[1]  = '{1'b1, 8'h42, 1'b0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 8'h41};
    tv[2]  = '{1'b1, 8'h43, 1'b0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 8'h41};
    tv[3]  = '{1'b0, 8'h00, 1'b1, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 8'h42};
    tv[4]  = '{1'b0, 8'h00, 1'b1, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h43};
    tv[5]  = '{1'b0, 8'h00, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[6]  = '{1'b0, 8'h00, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[7]  = '{1'b1, 8'h77, 1'b1, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h77};
    tv[8]  = '{1'b0, 8'h00, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[9]  = '{1'b1, 8'h01, 1'b0, 5'd4, 5'd1, 1'b0, 1'b0, 1'b1, 8'h01};
    tv[10] = '{1'b1, 8'h02, 1'b0, 5'd4, 5'd2, 1'b0, 1'b0, 1'b1, 8'h01};
    tv[11] = '{1'b1, 8'h03, 1'b0, 5'd4, 5'd3, 1'b0, 1'b0, 1'b1, 8'h01};
    tv[12] = '{1'b1, 8'h04, 1'b0, 5'd4, 5'd4, 1'b0, 1'b1, 1'b1, 8'h01};
    tv[13] = '{1'b0, 8'h00, 1'b1, 5'd4, 5'd3, 1'b0, 1'b0, 1'b1, 8'h02};
    tv[14] = '{1'b0, 8'h00, 1'b1, 5'd4, 5'd2, 1'b0, 1'b0, 1'b1, 8'h03};
    tv[15] = '{1'b0, 8'h00, 1'b1, 5'd4, 5'd1, 1'b0, 1'b0, 1'b1, 8'h04};
    tv[16] = '{1'b0, 8'h00, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};

    RSTn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rd_en = 1'b0;
    flush = 1'b0; ovf_clr = 1'b0; irq_thresh = 5'd0;
    #12;
    chk("reset empty", 32'(empty), 32'd1);
    chk("reset full", 32'(full), 32'd0);
    chk("reset count", 32'(count), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    chk("reset timeout", 32'(timeout), 32'd0);
    chk("reset irq", 32'(irq), 32'd0);
    RSTn = 1'b1;
    @(posedge clk); #1;

    // Table: ordering, empty-pop, empty push+pop, threshold level
    for (int i = 0; i < 17; i++) begin
      irq_thresh = tv[i].th;
      step(tv[i].rv, tv[i].d, tv[i].re, 1'b0, 1'b0);
      chk($sformatf("vec%0d count", i), 32'(count), 32'(tv[i].cnt));
      chk($sformatf("vec%0d empty", i), 32'(empty), 32'(tv[i].emp));
      chk($sformatf("vec%0d irq", i), 32'(irq), 32'(tv[i].irq));
      if (tv[i].chk_rd) chk($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(tv[i].rd));
    end
    irq_thresh = 5'd0;

    // Overflow: 17th byte dropped
    fill16(8'h00);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("ovf full", 32'(full), 32'd1);
    chk("ovf count", 32'(count), 32'd16);
    chk("ovf flag", 32'(ovf), 32'd1);
    chk("ovf irq", 32'(irq), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf pop%0d", i), 32'(rd_data), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("ovf drained empty", 32'(empty), 32'd1);
    chk("ovf still set", 32'(ovf), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(ovf), 32'd0);
    chk("ovf_clr irq", 32'(irq), 32'd0);

    // Full with simultaneous push and pop
    fill16(8'h00);
    chk("thresh0 full irq", 32'(irq), 32'd0);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("fullpp count", 32'(count), 32'd16);
    chk("fullpp ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fullpp pop%0d", i), 32'(rd_data), (i < 15) ? 32'(i + 1) : 32'h55);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("fullpp empty", 32'(empty), 32'd1);

    // Pointer wrap
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("wrap count10", 32'(count), 32'd10);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wrap pop%0d", i), 32'(rd_data), 32'h60 + 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("wrap empty", 32'(empty), 32'd1);

    // Idle timeout
    step(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    chk("to at push", 32'(timeout), 32'd0);
    idle_cycles(7);
    chk("to after 7", 32'(timeout), 32'd0);
    chk("to irq after 7", 32'(irq), 32'd0);
    idle_cycles(1);
    chk("to after 8", 32'(timeout), 32'd1);
    chk("to irq after 8", 32'(irq), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("to pop clears", 32'(timeout), 32'd0);
    chk("to pop irq", 32'(irq), 32'd0);
    chk("to pop count", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Flush leaves ovf alone and discards same-cycle push
    fill16(8'h10);
    step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("flush count", 32'(count), 32'd0);
    chk("flush keeps ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("flush pre count", 32'(count), 32'd5);
    step(1'b1, 8'hCC, 1'b1, 1'b1, 1'b0);
    chk("flush push count", 32'(count), 32'd0);
    chk("flush push empty", 32'(empty), 32'd1);
    chk("flush push ovf", 32'(ovf), 32'd1);
    fill16(8'h20);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("ovf set beats clr", 32'(ovf), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf clr2", 32'(ovf), 32'd0);
    step(1'b1, 8'hEF, 1'b0, 1'b1, 1'b0);
    chk("flush full no ovf", 32'(ovf), 32'd0);
    chk("flush full count", 32'(count), 32'd0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) step(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 1'b0);
    fill16(8'h00);
    RSTn = 1'b0;
    #1;
    chk("midrst count", 32'(count), 32'd0);
    chk("midrst empty", 32'(empty), 32'd1);
    chk("midrst ovf", 32'(ovf), 32'd0);
    chk("midrst irq", 32'(irq), 32'd0);
    #2;
    RSTn = 1'b1;
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    chk("postrst rd_data", 32'(rd_data), 32'h99);
    chk("postrst count", 32'(count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer between the UART receiver (one-cycle byte strobe per received character) and the AHB-Lite UART register interface (pops bytes on CPU reads). It decouples CPU read latency from line rate, reports fill level and overflow, and produces a single level interrupt for the NVIC IRQ line. The interrupt fires on a fill threshold, on an idle-line timeout with data pending, or on overflow. Single clock domain.

Parameters:
DEPTH, 16, number of byte entries; power of two, at least 2.
AW, 4, pointer width; equals log2(DEPTH).
TIMEOUT_CYC, 16'd4000, idle clk cycles with data pending before the timeout interrupt asserts; must be at least 1.

Ports:
clk  in  1  system clock
RSTn  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle strobe: rx_data holds a completed byte
rx_data  in  8  received byte
rd_en  in  1  pop request from the bus interface, one cycle per byte
rd_data  out  8  head-of-queue byte (show-ahead)
flush  in  1  synchronous clear of queue contents
ovf_clr  in  1  clears the overflow flag
irq_thresh  in  AW+1  fill-level interrupt threshold; 0 disables the level term
empty  out  1  queue holds no bytes
full  out  1  queue holds DEPTH bytes
count  out  AW+1  number of bytes held, 0..DEPTH
ovf  out  1  sticky overflow: a byte was dropped
timeout  out  1  idle timeout reached with data pending
irq  out  1  level interrupt request

Behaviour:
- Reset (RSTn low, asynchronous):
  - wr_ptr, rd_ptr, count, idle counter and ovf all go to 0.
  - Outputs: empty=1, full=0, count=0, ovf=0, timeout=0, irq=0.
  - rd_data is don't-care while empty. Storage array is not reset.
- Storage: DEPTH x 8 array. Pointers are AW bits and wrap modulo DEPTH (DEPTH-1 -> 0). count is kept as a separate AW+1-bit register.
- empty = (count==0); full = (count==DEPTH). Both are decoded from registered count.
- Push (accepted on clk edge): rx_valid && !full, or rx_valid && full && pop_ok.
  - Writes rx_data at wr_ptr; wr_ptr increments.
- Pop (pop_ok): rd_en && !empty.
  - rd_ptr increments. rd_data is the combinational read of mem[rd_ptr].
  - The popped byte is the one visible on rd_data in the same cycle as rd_en.
  - rd_en while empty is ignored; no pointer or count change.
- count next value: +1 for push only, -1 for pop only, unchanged when both or neither occur.
- Full boundary: rx_valid && full && !pop_ok drops the byte, leaves pointers unchanged and sets ovf on the next edge.
- Full with simultaneous pop: push accepted, count stays at DEPTH, no overflow.
- Empty with simultaneous rd_en and rx_valid: push accepted, pop ignored, count becomes 1.
  - Written data is visible on rd_data in the following cycle.
- flush: highest priority.
  - Next edge: both pointers=0, count=0, idle counter=0.
  - push and pop in the same cycle are discarded; no overflow is flagged for a discarded push.
  - ovf is not affected by flush.
- ovf: set by a dropped byte, cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
- Idle counter (16 bit):
  - Clears to 0 on any accepted push, any pop, or while empty.
  - Otherwise increments each cycle, saturating at TIMEOUT_CYC.
  - timeout = (idle counter == TIMEOUT_CYC); it therefore asserts TIMEOUT_CYC cycles after the last push/pop with data still held.
  - timeout deasserts the cycle after the next push or pop, or when the queue empties.
- irq = ((irq_thresh!=0) && (count>=irq_thresh)) || timeout || ovf.
  - Decoded only from registered state; no combinational path from any input to irq.
  - irq_thresh > DEPTH means the level term never fires.
- Latency:
  - Byte written on edge N: empty/count reflect it after edge N; readable by rd_en in cycle N+1.
  - Pop on edge N: count and rd_data update after edge N.
- Reset asserted mid-operation: immediate clear per the reset rules; queued data is lost. No partial state survives.

Test Plan:
- Reset, then 3 pushes of 0x41,0x42,0x43 with no reads -> count=3, empty=0; rd_data=0x41; 3 pops return 0x41,0x42,0x43 in order; then empty=1, count=0.
- Push 16 bytes 0x00..0x0F, then push 0xAA -> full=1, count=16, ovf=1, irq=1; pops return 0x00..0x0F (0xAA absent); ovf_clr -> ovf=0.
- Fill to 16, then rx_valid=0x55 together with rd_en -> count stays 16, ovf=0; 16 pops return 0x01..0x0F then 0x55.
- Wrap: 10 pushes/10 pops, then 10 more pushes 0x60..0x69 -> wr_ptr wraps to 4; pops return 0x60..0x69 in order.
- irq_thresh=4: after 3 pushes irq=0; after the 4th push irq=1; one pop -> irq=0. irq_thresh=0 with 16 bytes held and no timeout -> irq=0.
- TIMEOUT_CYC=8, irq_thresh=0: 1 push then idle -> timeout and irq assert exactly 8 cycles after the push edge; a pop clears both. flush with 5 bytes held and a simultaneous push -> count=0, empty=1, ovf unchanged.
